// File: rtl/tdc_pkg.sv
// Shared types for the multi-channel TDC: FSM state, interval record layout and a
// multi-hot helper. Record fields are sized for the largest supported configuration.
package tdc_pkg;

  localparam int TDC_MAX_CH    = 8;
  localparam int TDC_MAX_CNT_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } tdc_state_e;

  typedef struct packed {
    logic [TDC_MAX_CH-1:0]    start_mask;
    logic [TDC_MAX_CH-1:0]    stop_mask;
    logic [TDC_MAX_CNT_W-1:0] interval;
    logic                     coinc;
    logic                     overflow;
  } tdc_rec_t;

  // True when two or more bits are set (clearing the lowest set bit leaves something).
  function automatic logic is_multi(input logic [TDC_MAX_CH-1:0] m);
    return (m & (m - TDC_MAX_CH'(1))) != '0;
  endfunction

endpackage

// File: rtl/tdc_event_fifo.sv
// Synchronous record FIFO with async active-low reset on the pointers. A write while
// full is accepted only if a read frees the head slot on the same edge.
module tdc_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/tdc_multi_channel.sv
// N-channel start/stop TDC: timestamps each pulse arrival against the previous one and
// queues interval records. Define TDC_OVERFLOW_REPORT_EN to emit saturated intervals.
module tdc_multi_channel import tdc_pkg::*; #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_CH-1:0]   pulse_in,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [N_CH-1:0]   ev_start_mask,
  output logic [N_CH-1:0]   ev_stop_mask,
  output logic [CNT_W-1:0]  ev_interval,
  output logic              ev_coinc,
  output logic              ev_overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  MAX      = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  localparam int                REC_W    = 2*N_CH + CNT_W + 2;

  tdc_state_e        state;
  logic [N_CH-1:0]   pulse_q;
  logic [N_CH-1:0]   ref_mask;
  logic [CNT_W-1:0]  cnt;
  logic [N_CH-1:0]   edges;
  logic              arrival;
  logic              multi;
  logic              sat;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  tdc_rec_t          rec;
  logic              unused_rec;
  logic [REC_W-1:0]  wr_data;
  logic [REC_W-1:0]  rd_data;

  assign edges   = pulse_in & ~pulse_q;
  assign arrival = enable && (edges != '0);
  assign multi   = is_multi(TDC_MAX_CH'(edges));
  // cnt holds distance-1, so reaching MAX means the true distance exceeds MAX.
  assign sat     = (cnt == MAX);

  always_comb begin
    rec  = '0;
    push = 1'b0;
    if (arrival) begin
      if (multi) begin
        rec.start_mask = TDC_MAX_CH'(edges);
        rec.stop_mask  = TDC_MAX_CH'(edges);
        rec.coinc      = 1'b1;
        push           = 1'b1;
      end else if (state == ARMED) begin
        rec.start_mask = TDC_MAX_CH'(ref_mask);
        rec.stop_mask  = TDC_MAX_CH'(edges);
        rec.interval   = TDC_MAX_CNT_W'(sat ? MAX : cnt + CNT_W'(1));
`ifdef TDC_OVERFLOW_REPORT_EN
        rec.overflow   = sat;
        push           = 1'b1;
`else
        push           = !sat;
`endif
      end
    end
  end

  assign wr_data    = {rec.start_mask[N_CH-1:0], rec.stop_mask[N_CH-1:0],
                       rec.interval[CNT_W-1:0], rec.coinc, rec.overflow};
  assign unused_rec = ^rec;

  // Arrival stage: edge register, interval counter, FSM and drop accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pulse_q  <= '0;
      ref_mask <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      pulse_q <= pulse_in;
      if (arrival)         cnt <= '0;
      else if (cnt != MAX) cnt <= cnt + CNT_W'(1);
      if (!enable) begin
        state <= IDLE;
      end else if (arrival) begin
        state    <= ARMED;
        ref_mask <= edges;
      end
      if (push && full && !pop && (drop_cnt != DROP_MAX))
        drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  assign busy = (state == ARMED);
  assign pop  = ev_ready && !empty;

  tdc_event_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  // Output stage: head record, forced to zero while the FIFO is empty.
  assign ev_valid = !empty;
  assign {ev_start_mask, ev_stop_mask, ev_interval, ev_coinc, ev_overflow} =
    empty ? '0 : rd_data;

endmodule

// File: tb/tb_tdc_multi_channel.sv
// Directed bench for tdc_multi_channel (N_CH=2, CNT_W=4, FIFO_DEPTH=4); expectations
// for the saturated-interval case follow TDC_OVERFLOW_REPORT_EN.
module tb_tdc_multi_channel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [1:0]  pulse_in = '0;
  logic        ev_ready = 1'b1;
  logic        ev_valid;
  logic [1:0]  ev_start_mask;
  logic [1:0]  ev_stop_mask;
  logic [3:0]  ev_interval;
  logic        ev_coinc;
  logic        ev_overflow;
  logic [15:0] drop_cnt;
  logic        busy;
  logic [10:0] rec_now;
  logic [10:0] rec_exp;

  int checks = 0;
  int failures = 0;

  tdc_multi_channel #(
    .N_CH       (2),
    .CNT_W      (4),
    .FIFO_DEPTH (4),
    .DROP_W     (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .pulse_in      (pulse_in),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_start_mask (ev_start_mask),
    .ev_stop_mask  (ev_stop_mask),
    .ev_interval   (ev_interval),
    .ev_coinc      (ev_coinc),
    .ev_overflow   (ev_overflow),
    .drop_cnt      (drop_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // {valid, start, stop, interval, coinc, overflow}
  assign rec_now = {ev_valid, ev_start_mask, ev_stop_mask, ev_interval, ev_coinc, ev_overflow};

  task automatic drive(input logic [1:0] m);
    pulse_in = m;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    pulse_in = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    pulse_in = '0;
    enable   = 1'b1;
    ev_ready = 1'b1;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pulse_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rec_now, busy, drop_cnt} !== 28'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rec=%b busy=%b drop=%0d, want all zero", rec_now, busy, drop_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_interval();
    do_reset();
    drive(2'b01);
    checks++;
    if ({busy, ev_valid} !== 2'b10) begin
      failures++; $display("FAIL basic_arm: got busy,valid=%b want 10", {busy, ev_valid});
    end
    idle(4);
    checks++;
    if (ev_valid !== 1'b0) begin
      failures++; $display("FAIL basic_pre_valid: got %b want 0", ev_valid);
    end
    drive(2'b10);
    rec_exp = {1'b1, 2'b01, 2'b10, 4'd5, 1'b0, 1'b0};
    checks++;
    if (rec_now !== rec_exp) begin
      failures++; $display("FAIL basic_record: got %b want %b", rec_now, rec_exp);
    end
    idle(1);
    checks++;
    if (ev_valid !== 1'b0) begin
      failures++; $display("FAIL basic_valid_one_cycle: got %b want 0", ev_valid);
    end
  endtask

  task automatic test_coinc();
    do_reset();
    drive(2'b01);
    idle(2);
    drive(2'b11);
    rec_exp = {1'b1, 2'b11, 2'b11, 4'd0, 1'b1, 1'b0};
    checks++;
    if (rec_now !== rec_exp) begin
      failures++; $display("FAIL coinc_record: got %b want %b", rec_now, rec_exp);
    end
    idle(2);
    drive(2'b01);
    rec_exp = {1'b1, 2'b11, 2'b01, 4'd3, 1'b0, 1'b0};
    checks++;
    if (rec_now !== rec_exp) begin
      failures++; $display("FAIL coinc_followup: got %b want %b", rec_now, rec_exp);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(2'b01);
    idle(19);
    drive(2'b01);
`ifdef TDC_OVERFLOW_REPORT_EN
    rec_exp = {1'b1, 2'b01, 2'b01, 4'd15, 1'b0, 1'b1};
`else
    rec_exp = 11'd0;
`endif
    checks++;
    if (rec_now !== rec_exp) begin
      failures++; $display("FAIL overflow_record: got %b want %b", rec_now, rec_exp);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL overflow_busy: got %b want 1", busy);
    end
    idle(1);
    drive(2'b01);
    rec_exp = {1'b1, 2'b01, 2'b01, 4'd2, 1'b0, 1'b0};
    checks++;
    if (rec_now !== rec_exp) begin
      failures++; $display("FAIL overflow_after: got %b want %b", rec_now, rec_exp);
    end
  endtask

  task automatic test_fifo_full();
    logic [1:0] m;
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m = (i % 2 == 0) ? 2'b01 : 2'b10;
      drive(m);
      if (i < 5) idle(i + 1);
    end
    checks++;
    if (drop_cnt !== 16'd1) begin
      failures++; $display("FAIL full_drop_cnt: got %0d want 1", drop_cnt);
    end
    idle(3);
    rec_exp = {1'b1, 2'b01, 2'b10, 4'd2, 1'b0, 1'b0};
    checks++;
    if (rec_now !== rec_exp) begin
      failures++; $display("FAIL full_head_stable: got %b want %b", rec_now, rec_exp);
    end
    ev_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      rec_exp = {1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 2'b10 : 2'b01,
                 4'(k + 2), 1'b0, 1'b0};
      checks++;
      if (rec_now !== rec_exp) begin
        failures++; $display("FAIL full_drain_%0d: got %b want %b", k, rec_now, rec_exp);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({ev_valid, drop_cnt} !== 17'd1) begin
      failures++; $display("FAIL full_drained: got valid=%b drop=%0d want 0/1", ev_valid, drop_cnt);
    end
  endtask

  task automatic test_hold_and_enable();
    do_reset();
    pulse_in = 2'b01;
    repeat (10) begin @(posedge clk); #1; end
    checks++;
    if ({busy, ev_valid} !== 2'b10) begin
      failures++; $display("FAIL hold_single_arrival: got busy,valid=%b want 10", {busy, ev_valid});
    end
    idle(1);
    drive(2'b10);
    rec_exp = {1'b1, 2'b01, 2'b10, 4'd11, 1'b0, 1'b0};
    checks++;
    if (rec_now !== rec_exp) begin
      failures++; $display("FAIL hold_record: got %b want %b", rec_now, rec_exp);
    end
    idle(1);
    enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL disable_busy: got %b want 0", busy);
    end
    drive(2'b01);
    checks++;
    if ({busy, ev_valid} !== 2'b00) begin
      failures++; $display("FAIL disable_ignore: got busy,valid=%b want 00", {busy, ev_valid});
    end
    enable = 1'b1;
    idle(1);
    drive(2'b10);
    checks++;
    if ({busy, ev_valid} !== 2'b10) begin
      failures++; $display("FAIL reenable_arm_only: got busy,valid=%b want 10", {busy, ev_valid});
    end
    idle(1);
    drive(2'b01);
    rec_exp = {1'b1, 2'b10, 2'b01, 4'd2, 1'b0, 1'b0};
    checks++;
    if (rec_now !== rec_exp) begin
      failures++; $display("FAIL reenable_record: got %b want %b", rec_now, rec_exp);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive((i % 2 == 0) ? 2'b01 : 2'b10);
      idle(1);
    end
    checks++;
    if ({ev_valid, drop_cnt} !== 17'h10001) begin
      failures++; $display("FAIL areset_pre: got valid=%b drop=%0d want 1/1", ev_valid, drop_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ev_valid, drop_cnt, busy} !== 18'd0) begin
      failures++; $display("FAIL areset_immediate: got valid=%b drop=%0d busy=%b want 0", ev_valid, drop_cnt, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    checks++;
    if (rec_now !== 11'd0) begin
      failures++; $display("FAIL areset_no_partial: got %b want 0", rec_now);
    end
  endtask

  initial begin
    test_reset();
    test_basic_interval();
    test_coinc();
    test_overflow();
    test_fifo_full();
    test_hold_and_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
